// File: rtl/demux_1_n_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_1_n_reg : 1-to-M registered demux, one holding slot per port,       |
// |                 sticky bad-select flag and delivered-word counter.        |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module demux_1_n_reg #(
  parameter int N = 32,
  parameter int M = 32,
  parameter int S = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [S-1:0]     in_sel,
  output logic [M-1:0]     out_valid,
  input  logic [M-1:0]     out_ready,
  output logic [M*N-1:0]   out_data,
  output logic             sel_err,
  output logic [31:0]      xfer_count
);

  localparam logic [31:0] c_num_ports = 32'(M);

  logic           w_sel_in_range;
  logic           w_sel_ready;
  logic           w_in_fire;
  logic [M-1:0]   w_port_valid;
  logic [M-1:0]   w_load;
  logic [M-1:0]   w_drain;
  logic [31:0]    w_drain_cnt;
  logic           r_sel_err;
  logic [31:0]    r_xfer_count;

  assign w_sel_in_range = (32'(in_sel) < c_num_ports);

  // Out-of-range selects match no port and keep the default of ready.
  always_comb begin
    w_sel_ready = 1'b1;
    for (int k = 0; k < M; k++) begin
      if (in_sel == S'(k)) begin
        w_sel_ready = !w_port_valid[k] || out_ready[k];
      end
    end
  end

  assign in_ready  = w_sel_ready;
  assign w_in_fire = in_valid && w_sel_ready;
  assign w_drain   = w_port_valid & out_ready;

  always_comb begin
    w_drain_cnt = '0;
    for (int k = 0; k < M; k++) begin
      w_drain_cnt = w_drain_cnt + {31'd0, w_drain[k]};
    end
  end

  generate
    for (genvar k = 0; k < M; k++) begin : g_port
      logic         r_valid;
      logic [N-1:0] r_data;

      assign w_load[k] = w_in_fire && (in_sel == S'(k));

      // A load wins over a drain so a word can be replaced with no bubble.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
        end else if (w_load[k]) begin
          r_valid <= 1'b1;
        end else if (w_drain[k]) begin
          r_valid <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (w_load[k]) begin
          r_data <= in_data;
        end
      end

      assign w_port_valid[k]     = r_valid;
      assign out_data[k*N +: N]  = r_data;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err    <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      if (in_valid && !w_sel_in_range) begin
        r_sel_err <= 1'b1;
      end
      r_xfer_count <= r_xfer_count + w_drain_cnt;
    end
  end

  assign out_valid  = w_port_valid;
  assign sel_err    = r_sel_err;
  assign xfer_count = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_demux_1_n_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_demux_1_n_reg : directed and scoreboard checks for demux_1_n_reg.      |
// | Revision         : 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_demux_1_n_reg;
  localparam int N = 32;
  localparam int M = 20;
  localparam int S = $clog2(M);

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic [S-1:0]   in_sel;
  logic [M-1:0]   out_valid;
  logic [M-1:0]   out_ready;
  logic [M*N-1:0] out_data;
  logic           sel_err;
  logic [31:0]    xfer_count;

  demux_1_n_reg #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sel_err    (sel_err),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [N-1:0] q [M][$];
  logic [M-1:0] exp_vld;
  logic         exp_rdy;
  logic         exp_err;
  logic [31:0]  exp_xfer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] slice(input int k);
    return out_data[k*N +: N];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_sel_err", 32'(sel_err), 32'h0);
    check("rst_xfer", xfer_count, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    tick();
    tick();
    rst_n = 1'b1;

    // Single load to port 3, held with no consumer.
    in_sel   = S'(3);
    in_data  = 32'hDEADBEEF;
    in_valid = 1'b1;
    #1;
    check("load_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("load_out_valid", 32'(out_valid), 32'h8);
    check("load_slice3", slice(3), 32'hDEADBEEF);
    tick();
    tick();
    tick();
    check("hold_out_valid", 32'(out_valid), 32'h8);
    check("hold_slice3", slice(3), 32'hDEADBEEF);

    // Back-pressure, then replace-on-drain with no bubble.
    in_data  = 32'hCAFEF00D;
    in_valid = 1'b1;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("bp_slice3", slice(3), 32'hDEADBEEF);
    check("bp_out_valid", 32'(out_valid), 32'h8);
    out_ready = 20'h8;
    #1;
    check("pass_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid  = 1'b0;
    out_ready = '0;
    check("pass_out_valid", 32'(out_valid), 32'h8);
    check("pass_slice3", slice(3), 32'hCAFEF00D);
    check("pass_xfer", xfer_count, 32'd1);
    out_ready = 20'h8;
    tick();
    out_ready = '0;
    check("drain_out_valid", 32'(out_valid), 32'h0);
    check("drain_xfer", xfer_count, 32'd2);

    // Fill every port, then drain all in one cycle.
    for (int k = 0; k < M; k++) begin
      in_sel   = S'(k);
      in_data  = 32'h100 + 32'(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("fill_out_valid", 32'(out_valid), 32'hFFFFF);
    check("fill_slice0", slice(0), 32'h100);
    check("fill_slice7", slice(7), 32'h107);
    check("fill_slice19", slice(19), 32'h113);
    out_ready = '1;
    tick();
    out_ready = '0;
    check("all_drain_out_valid", 32'(out_valid), 32'h0);
    check("all_drain_xfer", xfer_count, 32'd22);

    // Out-of-range select is accepted and discarded.
    in_sel   = S'(25);
    in_data  = 32'h12345678;
    in_valid = 1'b1;
    #1;
    check("bad_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("bad_sel_err", 32'(sel_err), 32'h1);
    check("bad_out_valid", 32'(out_valid), 32'h0);
    check("bad_xfer", xfer_count, 32'd22);

    // Idle inputs change nothing; sel_err stays sticky.
    in_sel  = S'(5);
    in_data = 32'h55555555;
    tick();
    tick();
    check("idle_out_valid", 32'(out_valid), 32'h0);
    check("idle_sel_err", 32'(sel_err), 32'h1);

    // Asynchronous reset between edges with words held.
    for (int k = 0; k < 4; k++) begin
      in_sel   = S'(k);
      in_data  = 32'hA0 + 32'(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'hF);
    #2;
    rst_n     = 1'b0;
    out_ready = 20'hF;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'h0);
    check("async_rst_xfer", xfer_count, 32'h0);
    check("async_rst_sel_err", 32'(sel_err), 32'h0);
    tick();
    check("in_rst_xfer", xfer_count, 32'h0);
    out_ready = '0;
    rst_n     = 1'b1;

    // Random traffic against per-port scoreboard queues.
    exp_err  = 1'b0;
    exp_xfer = '0;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(1, 0));
      in_sel    = S'($urandom_range(24, 0));
      in_data   = $urandom();
      out_ready = M'($urandom());
      #1;
      for (int k = 0; k < M; k++) exp_vld[k] = (q[k].size() != 0);
      check("rnd_out_valid", 32'(out_valid), 32'(exp_vld));
      exp_rdy = (32'(in_sel) >= M) ? 1'b1 : (!exp_vld[in_sel] || out_ready[in_sel]);
      check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      for (int k = 0; k < M; k++) begin
        if (exp_vld[k] && out_ready[k]) begin
          check("rnd_data", slice(k), q[k].pop_front());
          exp_xfer = exp_xfer + 32'd1;
        end
      end
      if (in_valid && exp_rdy) begin
        if (32'(in_sel) < M) q[in_sel].push_back(in_data);
        else exp_err = 1'b1;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = '0;
    #1;
    check("rnd_xfer", xfer_count, exp_xfer);
    check("rnd_sel_err", 32'(sel_err), 32'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_1_n_reg.md
DEMUX_1_N_REG -- requirements
Module: demux_1_n_reg

Interface
REQ-001 Parameter: N, 32, data width in bits.
REQ-002 Parameter: M, 32, number of output ports (2..32).
REQ-003 Parameter: S, $clog2(M), select width (derived; never overridden).
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port: in_valid  input  1  upstream word present.
REQ-007 Port: in_ready  output  1  demux accepts upstream word this cycle.
REQ-008 Port: in_data  input  N  upstream word.
REQ-009 Port: in_sel  input  S  destination port index for in_data.
REQ-010 Port: out_valid  output  M  bit k: port k holds a word.
REQ-011 Port: out_ready  input  M  bit k: consumer k takes word this cycle.
REQ-012 Port: out_data  output  M*N  packed; slice [k*N +: N] is port k's word.
REQ-013 Port: sel_err  output  1  sticky; an out-of-range in_sel was accepted.
REQ-014 Port: xfer_count  output  32  count of words delivered on all output ports.

Function
REQ-015 Each port k SHALL own one N-bit holding register plus a valid flag; there is no other buffering.
REQ-016 Input handshake SHALL fire when in_valid && in_ready are both 1 in the same cycle.
REQ-017 Output handshake k SHALL fire when out_valid[k] && out_ready[k] are both 1 in the same cycle.
REQ-018 For in_sel < M: in_ready SHALL equal !out_valid[in_sel] || out_ready[in_sel], combinationally.
REQ-019 For in_sel >= M: in_ready SHALL be 1; the word is discarded and sel_err set to 1 on that edge.
REQ-020 On an input handshake with in_sel = k < M, port k register SHALL load in_data and out_valid[k] SHALL be 1 from the next cycle (latency 1).
REQ-021 If port k fires its output handshake in the same cycle it is loaded, the new word SHALL replace the old one and out_valid[k] SHALL stay 1, with no bubble.
REQ-022 On an output handshake without a load, out_valid[k] SHALL clear on the next edge.
REQ-023 out_data slice k SHALL hold its value while out_valid[k]=1 and out_ready[k]=0.
REQ-024 out_data slice k SHALL be don't-care while out_valid[k]=0.
REQ-025 Ports other than in_sel SHALL be unaffected by the input handshake; all M ports drain independently and concurrently.
REQ-026 xfer_count SHALL add popcount(out_valid & out_ready) each cycle and wrap modulo 2^32.
REQ-027 in_ready, in_data, and in_sel SHALL NOT affect any state when in_valid=0.
REQ-028 Words to the same port SHALL leave in acceptance order; ordering across ports is not defined.

Reset
REQ-029 While rst_n=0, out_valid SHALL be all 0, sel_err 0, and xfer_count 0, immediately and independently of clk.
REQ-030 Holding registers SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all held words, with no output handshake completing on that edge.
REQ-032 in_ready SHALL still follow REQ-018/019 during reset, so with all out_valid=0 it reads 1; no state changes until rst_n=1.
REQ-033 The first load SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 Scenario: reset, then in_sel=3, in_data=0xDEADBEEF, in_valid=1 for 1 cycle, out_ready=0 -> next cycle out_valid=0x00000008, slice 3=0xDEADBEEF, held indefinitely.
REQ-035 Scenario: port 3 full with out_ready[3]=0, in_sel=3, in_valid=1 -> in_ready=0 and the held word is unchanged. Then raise out_ready[3] -> in_ready=1 same cycle; next cycle slice 3 holds the new word, out_valid[3] stays 1, xfer_count=1.
REQ-036 Scenario: for k=0..M-1, send word k+0x100 to port k with all out_ready=0 -> out_valid all ones. Then set all out_ready=1 for 1 cycle -> out_valid=0, xfer_count=M.
REQ-037 Scenario: M=20, in_sel=25, in_valid=1 -> in_ready=1, sel_err=1 next cycle, out_valid unchanged, xfer_count unchanged.
REQ-038 Scenario: ports 0..3 loaded, rst_n pulled low between edges -> out_valid=0 and xfer_count=0 before the next edge.
REQ-039 Scenario: 1000 iterations of random in_sel, in_data, and out_ready with a scoreboard of per-port FIFOs -> every delivered word matches in order, with no loss or duplication; out-of-range selects excluded.
